// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: hsync/vsync/de/frame_start from run-time
// geometry, with frame-aligned start/stop and per-frame parameter shadowing.
module video_timing_gen #(
  parameter int H_WIDTH   = 12,
  parameter int V_WIDTH   = 12,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               busy,
  input  logic [H_WIDTH-1:0] param_h_visible,
  input  logic [H_WIDTH-1:0] param_h_frontporch,
  input  logic [H_WIDTH-1:0] param_h_pulse,
  input  logic [H_WIDTH-1:0] param_h_backporch,
  input  logic [V_WIDTH-1:0] param_v_visible,
  input  logic [V_WIDTH-1:0] param_v_frontporch,
  input  logic [V_WIDTH-1:0] param_v_pulse,
  input  logic [V_WIDTH-1:0] param_v_backporch,
  output logic               out_hsync,
  output logic               out_vsync,
  output logic               out_de,
  output logic               out_frame_start
);

  typedef struct packed {
    logic [H_WIDTH-1:0] h_vis, h_fp, h_pw, h_bp;
    logic [V_WIDTH-1:0] v_vis, v_fp, v_pw, v_bp;
  } geom_t;

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [H_WIDTH:0]   HT_ONE = {{H_WIDTH{1'b0}}, 1'b1};
  localparam logic [V_WIDTH:0]   VT_ONE = {{V_WIDTH{1'b0}}, 1'b1};
  localparam logic [H_WIDTH-1:0] H_INC  = {{(H_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [V_WIDTH-1:0] V_INC  = {{(V_WIDTH-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  geom_t              shd_q, geom_in, geom_d;
  logic [H_WIDTH-1:0] h_q, h_d;
  logic [V_WIDTH-1:0] v_q, v_d;
  logic [H_WIDTH:0]   htot_q, hs_beg, hs_end;
  logic [V_WIDTH:0]   vtot_q, vs_beg, vs_end;
  logic               last_h, last_v, last_px, start, run_d;
  logic               de_d, hs_d, vs_d, fs_d;

  // Totals come from the shadow copy so mid-frame input changes cannot move the wrap point.
  assign htot_q = {1'b0, shd_q.h_vis} + {1'b0, shd_q.h_fp} + {1'b0, shd_q.h_pw} + {1'b0, shd_q.h_bp};
  assign vtot_q = {1'b0, shd_q.v_vis} + {1'b0, shd_q.v_fp} + {1'b0, shd_q.v_pw} + {1'b0, shd_q.v_bp};
  assign last_h = ({1'b0, h_q} == htot_q - HT_ONE);
  assign last_v = ({1'b0, v_q} == vtot_q - VT_ONE);

  always_comb begin
    geom_in = '{h_vis: param_h_visible, h_fp: param_h_frontporch,
                h_pw:  param_h_pulse,   h_bp: param_h_backporch,
                v_vis: param_v_visible, v_fp: param_v_frontporch,
                v_pw:  param_v_pulse,   v_bp: param_v_backporch};
    last_px = (state_q == RUN) && last_h && last_v;
    start   = enable && ((state_q == IDLE) || last_px);
    state_d = state_q;
    geom_d  = shd_q;
    h_d     = '0;
    v_d     = '0;
    if (start) begin
      state_d = RUN;
      geom_d  = geom_in;
    end else if (last_px) begin
      state_d = IDLE;
    end else if (state_q == RUN) begin
      if (last_h) begin
        v_d = v_q + V_INC;
      end else begin
        h_d = h_q + H_INC;
        v_d = v_q;
      end
    end
    run_d = (state_d == RUN);

    // Decode the position being entered, against the geometry that will own it.
    hs_beg = {1'b0, geom_d.h_vis} + {1'b0, geom_d.h_fp};
    hs_end = hs_beg + {1'b0, geom_d.h_pw};
    vs_beg = {1'b0, geom_d.v_vis} + {1'b0, geom_d.v_fp};
    vs_end = vs_beg + {1'b0, geom_d.v_pw};
    de_d   = run_d && (h_d < geom_d.h_vis) && (v_d < geom_d.v_vis);
    hs_d   = run_d && ({1'b0, h_d} >= hs_beg) && ({1'b0, h_d} < hs_end);
    vs_d   = run_d && ({1'b0, v_d} >= vs_beg) && ({1'b0, v_d} < vs_end);
    fs_d   = run_d && (h_d == '0) && (v_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      shd_q           <= '0;
      h_q             <= '0;
      v_q             <= '0;
      busy            <= 1'b0;
      out_de          <= 1'b0;
      out_frame_start <= 1'b0;
      out_hsync       <= ~HSYNC_POL;
      out_vsync       <= ~VSYNC_POL;
    end else begin
      state_q         <= state_d;
      shd_q           <= geom_d;
      h_q             <= h_d;
      v_q             <= v_d;
      busy            <= run_d;
      out_de          <= de_d;
      out_frame_start <= fs_d;
      out_hsync       <= hs_d ? HSYNC_POL : ~HSYNC_POL;
      out_vsync       <= vs_d ? VSYNC_POL : ~VSYNC_POL;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: vector table, directed frame sequences and a
// randomized run checked against a frame-index reference model.
module tb_video_timing_gen;

  localparam bit HP = 1'b1;
  localparam bit VP = 1'b0;

  typedef struct {
    int hv, hf, hp, hb, vv, vf, vp, vb;
  } geom_t;

  typedef struct {
    bit         en;
    bit         rst;
    logic [4:0] exp;  // {busy, de, hsync, vsync, frame_start}
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        busy;
  logic [11:0] param_h_visible, param_h_frontporch, param_h_pulse, param_h_backporch;
  logic [11:0] param_v_visible, param_v_frontporch, param_v_pulse, param_v_backporch;
  logic        out_hsync, out_vsync, out_de, out_frame_start;

  int    n_checks = 0;
  int    n_fail   = 0;
  geom_t cur_g;
  bit    m_run;
  int    m_k;
  geom_t m_g;

  video_timing_gen #(.H_WIDTH(12), .V_WIDTH(12), .HSYNC_POL(HP), .VSYNC_POL(VP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .busy(busy),
    .param_h_visible(param_h_visible), .param_h_frontporch(param_h_frontporch),
    .param_h_pulse(param_h_pulse), .param_h_backporch(param_h_backporch),
    .param_v_visible(param_v_visible), .param_v_frontporch(param_v_frontporch),
    .param_v_pulse(param_v_pulse), .param_v_backporch(param_v_backporch),
    .out_hsync(out_hsync), .out_vsync(out_vsync), .out_de(out_de),
    .out_frame_start(out_frame_start)
  );

  always #5 clk = ~clk;

  function automatic geom_t mk(input int hv, hf, hp, hb, vv, vf, vp, vb);
    geom_t g;
    g.hv = hv; g.hf = hf; g.hp = hp; g.hb = hb;
    g.vv = vv; g.vf = vf; g.vp = vp; g.vb = vb;
    return g;
  endfunction

  task automatic set_geom(input geom_t g);
    cur_g = g;
    param_h_visible = g.hv[11:0]; param_h_frontporch = g.hf[11:0];
    param_h_pulse   = g.hp[11:0]; param_h_backporch  = g.hb[11:0];
    param_v_visible = g.vv[11:0]; param_v_frontporch = g.vf[11:0];
    param_v_pulse   = g.vp[11:0]; param_v_backporch  = g.vb[11:0];
  endtask

  // Reference: position is a pixel index k within the frame; h,v follow by division.
  task automatic model_step(input bit en, input bit rst);
    int tot;
    if (rst) begin
      m_run = 1'b0; m_k = 0; m_g = '{default: 0};
    end else if (!m_run) begin
      if (en) begin m_run = 1'b1; m_k = 0; m_g = cur_g; end
    end else begin
      tot = (m_g.hv + m_g.hf + m_g.hp + m_g.hb) * (m_g.vv + m_g.vf + m_g.vp + m_g.vb);
      if (m_k == tot - 1) begin
        if (en) begin m_k = 0; m_g = cur_g; end
        else begin m_run = 1'b0; m_k = 0; end
      end else begin
        m_k++;
      end
    end
  endtask

  function automatic logic [4:0] model_out();
    int ht, h, v;
    logic de, hs, vs, fs;
    if (!m_run) return {1'b0, 1'b0, ~HP, ~VP, 1'b0};
    ht = m_g.hv + m_g.hf + m_g.hp + m_g.hb;
    h  = m_k % ht;
    v  = m_k / ht;
    de = (h < m_g.hv) && (v < m_g.vv);
    hs = (h >= m_g.hv + m_g.hf) && (h < m_g.hv + m_g.hf + m_g.hp);
    vs = (v >= m_g.vv + m_g.vf) && (v < m_g.vv + m_g.vf + m_g.vp);
    fs = (m_k == 0);
    return {1'b1, de, hs ? HP : ~HP, vs ? VP : ~VP, fs};
  endfunction

  function automatic logic [4:0] dut_out();
    return {busy, out_de, out_hsync, out_vsync, out_frame_start};
  endfunction

  task automatic check_vec(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: {busy,de,hs,vs,fs} got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s @%0t: bound expired", name, $time);
  endtask

  task automatic tick(input bit en, input bit rst);
    enable = en;
    reset  = rst;
    @(posedge clk);
    model_step(en, rst);
    #1;
    check_vec("model", dut_out(), model_out());
  endtask

  // Ticks until the next frame start or until busy drops; n = ticks taken.
  task automatic count_until(input bit en, input int bound, output int n);
    n = 0;
    while (n < bound) begin
      tick(en, 1'b0);
      n++;
      if (out_frame_start || !busy) return;
    end
    timeout("count_until");
  endtask

  // Called while out_frame_start is high; gathers per-frame statistics.
  task automatic run_frame(input int bound, output int len, output int de_n, output int hs_n,
                           output int vs_n, output int vs_first, output int de_run);
    int run;
    len = 0; de_n = 0; hs_n = 0; vs_n = 0; vs_first = -1; de_run = 0; run = 0;
    while (len < bound) begin
      if (out_de) begin run++; de_n++; if (run > de_run) de_run = run; end
      else run = 0;
      if (out_hsync == HP) hs_n++;
      if (out_vsync == VP) begin if (vs_first < 0) vs_first = len; vs_n++; end
      tick(1'b1, 1'b0);
      len++;
      if (out_frame_start || !busy) return;
    end
    timeout("run_frame");
  endtask

  vec_t  vecs[11];
  geom_t tiny;
  int    n, len, de_n, hs_n, vs_n, vs_first, de_run, first_hs;

  initial begin
    tiny = mk(4, 1, 2, 1, 3, 1, 1, 1);
    set_geom(tiny);

    // Tiny raster, first line and a half from reset (htotal 8, vtotal 6)
    vecs[0]  = '{en: 1'b0, rst: 1'b1, exp: 5'b00010};
    vecs[1]  = '{en: 1'b0, rst: 1'b0, exp: 5'b00010};
    vecs[2]  = '{en: 1'b1, rst: 1'b0, exp: 5'b11011};
    vecs[3]  = '{en: 1'b1, rst: 1'b0, exp: 5'b11010};
    vecs[4]  = '{en: 1'b1, rst: 1'b0, exp: 5'b11010};
    vecs[5]  = '{en: 1'b1, rst: 1'b0, exp: 5'b11010};
    vecs[6]  = '{en: 1'b1, rst: 1'b0, exp: 5'b10010};
    vecs[7]  = '{en: 1'b1, rst: 1'b0, exp: 5'b10110};
    vecs[8]  = '{en: 1'b1, rst: 1'b0, exp: 5'b10110};
    vecs[9]  = '{en: 1'b1, rst: 1'b0, exp: 5'b10010};
    vecs[10] = '{en: 1'b1, rst: 1'b0, exp: 5'b11010};
    for (int i = 0; i < 11; i++) begin
      tick(vecs[i].en, vecs[i].rst);
      check_vec($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
    end

    // Finish frame 0 (at pixel 8), then measure a full tiny frame
    count_until(1'b1, 100, n);
    check_int("tiny_rest_of_frame0", n, 40);
    run_frame(100, len, de_n, hs_n, vs_n, vs_first, de_run);
    check_int("tiny_period", len, 48);
    check_int("tiny_de_cycles", de_n, 12);
    check_int("tiny_de_run", de_run, 4);
    check_int("tiny_hs_cycles", hs_n, 12);
    check_int("tiny_vs_cycles", vs_n, 8);
    check_int("tiny_vs_first", vs_first, 32);

    // Stop mid-frame: frame completes, busy drops one cycle after the last pixel
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
    count_until(1'b0, 100, n);
    check_int("stop_ticks", n, 38);
    check_vec("stop_idle", dut_out(), 5'b00010);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    check_vec("restart_fs", dut_out(), 5'b11011);

    // Enable glitch mid-frame is ignored
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
    count_until(1'b1, 100, n);
    check_int("glitch_ticks", n, 33);
    check_int("glitch_busy", int'(busy), 1);

    // h_visible 4 -> 6 mid-frame: current frame unchanged, next is 60 cycles
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    set_geom(mk(6, 1, 2, 1, 3, 1, 1, 1));
    count_until(1'b1, 100, n);
    check_int("pchg_cur_frame", n, 43);
    run_frame(200, len, de_n, hs_n, vs_n, vs_first, de_run);
    check_int("pchg_period", len, 60);
    check_int("pchg_de_cycles", de_n, 18);
    check_int("pchg_de_run", de_run, 6);

    // Zero pulse widths: syncs stay inactive, period is the remaining sum
    set_geom(mk(4, 1, 0, 1, 3, 1, 0, 1));
    count_until(1'b1, 100, n);
    check_int("zp_prev_frame", n, 60);
    run_frame(100, len, de_n, hs_n, vs_n, vs_first, de_run);
    check_int("zp_period", len, 30);
    check_int("zp_hs_cycles", hs_n, 0);
    check_int("zp_vs_cycles", vs_n, 0);

    // 640x480: first three lines
    set_geom(mk(640, 16, 96, 48, 480, 10, 2, 33));
    count_until(1'b1, 100, n);
    check_int("vga_entry", n, 30);
    first_hs = -1; hs_n = 0; de_n = 0;
    for (int i = 0; i < 2400; i++) begin
      if (out_hsync == HP) begin if (first_hs < 0) first_hs = i; hs_n++; end
      if (out_de) de_n++;
      tick(1'b1, 1'b0);
    end
    check_int("vga_hs_first", first_hs, 656);
    check_int("vga_hs_cycles", hs_n, 288);
    check_int("vga_de_cycles", de_n, 1920);

    // Reset during an hsync pulse, release with enable held
    set_geom(tiny);
    n = 0;
    while (out_hsync != HP && n < 1000) begin tick(1'b1, 1'b0); n++; end
    if (n >= 1000) timeout("wait_hsync");
    tick(1'b1, 1'b1);
    check_vec("rst_mid_idle", dut_out(), 5'b00010);
    tick(1'b1, 1'b0);
    check_vec("rst_release_fs", dut_out(), 5'b11011);

    // Randomized geometry, enable and occasional reset against the model
    for (int s = 0; s < 20; s++) begin
      set_geom(mk($urandom_range(1, 5), $urandom_range(0, 2), $urandom_range(0, 2),
                  $urandom_range(0, 2), $urandom_range(1, 4), $urandom_range(0, 2),
                  $urandom_range(0, 2), $urandom_range(0, 2)));
      for (int i = 0; i < 300; i++)
        tick($urandom_range(0, 15) != 0, $urandom_range(0, 199) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Programmable raster timing generator for the video output path. It produces hsync, vsync and de in the video clock domain. These drive the timing inputs of the AXI4-Stream-to-video stage that feeds the DVI transmitter. It replaces the fixed-timing pattern generator with run-time geometry, frame-aligned start/stop, and a frame-start marker.

## Interface
- H_WIDTH, 12: width of horizontal count and horizontal parameters.
- V_WIDTH, 12: width of vertical count and vertical parameters.
- HSYNC_POL, 0: active level of out_hsync (0 = active-low).
- VSYNC_POL, 0: active level of out_vsync (0 = active-low).

Ports:
- clk  in  1  video pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  request to run; sampled only at the frame boundary or while idle.
- busy  out  1  high while generating frames.
- param_h_visible / param_h_frontporch / param_h_pulse / param_h_backporch  in  H_WIDTH each  horizontal geometry in pixels.
- param_v_visible / param_v_frontporch / param_v_pulse / param_v_backporch  in  V_WIDTH each  vertical geometry in lines.
- out_hsync  out  1  horizontal sync at HSYNC_POL.
- out_vsync  out  1  vertical sync at VSYNC_POL.
- out_de  out  1  active-video enable.
- out_frame_start  out  1  one-cycle pulse on pixel (0,0) of each frame.

## Operation
- Two states, IDLE and RUN. Internal counters h (0..htotal-1) and v (0..vtotal-1).
- htotal = h_visible + h_frontporch + h_pulse + h_backporch. vtotal is formed the same way from the vertical parameters.
- Each line runs visible, then front porch, then sync, then back porch. Frames follow the same order in lines.
- Parameters are latched into shadow registers on every frame start. Changes mid-frame take effect from the next frame only.
- Parameter constraints:
  - visible ≥ 1.
  - Porches and pulse may be 0; pulse = 0 means the sync output never asserts.
  - htotal ≤ 2^H_WIDTH and vtotal ≤ 2^V_WIDTH. Sums are computed one bit wider than the parameter width. Behaviour outside these limits is undefined.
- Output decode for position (h,v):
  - out_de = (h < h_visible) && (v < v_visible).
  - out_hsync is active for h_visible + h_frontporch ≤ h < h_visible + h_frontporch + h_pulse, on every line including vertical blanking.
  - out_vsync is active for whole lines v_visible + v_frontporch ≤ v < v_visible + v_frontporch + v_pulse, and changes only at h = 0.
  - out_frame_start = (h == 0 && v == 0).
- IDLE → RUN: on a clock edge with enable = 1:
  - latch parameters;
  - set h = v = 0;
  - set busy to 1.
- RUN, not at last pixel: h increments; when h wraps to 0, v increments.
- RUN, at last pixel (h = htotal-1, v = vtotal-1):
  - if enable = 1: set h = v = 0, relatch parameters, stay in RUN. No gap cycle.
  - if enable = 0: go to IDLE and set busy to 0.
- enable is ignored mid-frame. Frames are never truncated, and deassert/reassert pulses within a frame are not seen.

## Timing
- Every output is a register. On the edge that moves the counters to (h,v), the outputs take the decoded values for (h,v). There is no added pipeline latency.
- First active cycle: enable is sampled at edge E in IDLE. In the cycle after E, busy = 1, out_frame_start = 1, and out_de = 1 (position (0,0)).
- Stop: in the cycle after the edge that completes the last pixel with enable = 0:
  - busy = 0 and out_de = 0;
  - both syncs are at their inactive level;
  - out_frame_start = 0.
- IDLE output values: out_de = 0, out_frame_start = 0, out_hsync = ~HSYNC_POL, out_vsync = ~VSYNC_POL.
- Reset takes priority over everything, including mid-frame. After reset:
  - state = IDLE, h = v = 0, busy = 0;
  - outputs at their IDLE values;
  - shadow parameters = 0.
- With enable held at 1 through reset, the first frame starts on the edge after reset is released.
- Frame period = htotal × vtotal cycles exactly. Consecutive out_frame_start pulses are exactly that far apart.

## Test plan
- 640x480 timing (H 640/16/96/48, V 480/10/2/33, enable held at 1):
  - out_frame_start period is 420000 cycles;
  - 307200 de cycles per frame;
  - hsync active for 96 cycles starting at h = 656 on all 525 lines;
  - vsync active on lines 490–491, i.e. 1600 cycles.
- Tiny raster (H 4/1/2/1, V 3/1/1/1):
  - frame = 48 cycles;
  - de is high for 4 cycles per line on lines 0–2 only;
  - hsync active at h = 5..6;
  - vsync active for cycles 32..39 of the frame;
  - compare cycle-by-cycle against a reference model.
- Stop/restart:
  - drop enable mid-frame: the frame completes, and busy falls exactly 1 cycle after the last pixel;
  - pulse enable low for 10 cycles mid-frame: no effect on output;
  - re-enable in IDLE: out_frame_start appears 1 cycle later.
- Parameter change: switch h_visible from 4 to 6 mid-frame → the current frame is unchanged, and the next frame is 60 cycles long with 6-cycle de runs.
- Zero pulse: h_pulse = 0 and v_pulse = 0 → syncs never leave the inactive level; the frame period is still the sum of the remaining fields.
- Reset mid-frame, with HSYNC_POL = 1:
  - reset asserted during an hsync pulse: in the next cycle all outputs are at IDLE values and busy = 0;
  - on release with enable = 1: out_frame_start arrives 1 cycle later.
